// File: rtl/reg_map_recovery_sequencer.sv
// reg_map_recovery_sequencer
// Sequences recovery of the rename state after a kill from dispatch.
// The sequencer first tries a one-cycle checkpoint restore. If no checkpoint
// can be restored, it walks the ROB from the youngest entry to the oldest and
// issues one revert per cycle. Dispatch stays stalled until recovery is done.
// At the end, the ROB tail is moved to the slot just after the killing instr.
//
// Ports
//   CLK, nRST                       clock, asynchronous active-low reset
//   DUT_error                       registered one-cycle protocol-violation flag
//   kill_*                          kill request: surviving ROB index, checkpoint column
//   ROB_head_index/ROB_tail_index   age reference and allocation boundary
//   restore_checkpoint_*            checkpoint restore request; same-cycle success reply
//   ROB_read_*                      walk pointer out, combinational entry fields in
//   revert_*                        one-cycle revert to the free list and map table
//   ROB_tail_set_*                  one-cycle ROB tail update pulse
//   dispatch_stall                  combinational stall to dispatch
module reg_map_recovery_sequencer #(
    parameter int unsigned ROB_DEPTH        = 16,
    parameter int unsigned LOG_ROB_DEPTH    = 4,
    parameter int unsigned ARCH_REG_W       = 5,
    parameter int unsigned PHYS_REG_W       = 6,
    parameter int unsigned LOG_CKPT_COLUMNS = 2
) (
    input  logic                        CLK,
    input  logic                        nRST,
    output logic                        DUT_error,

    input  logic                        kill_valid,
    input  logic [LOG_ROB_DEPTH-1:0]    kill_ROB_index,
    input  logic [LOG_CKPT_COLUMNS-1:0] kill_checkpoint_column,
    input  logic [LOG_ROB_DEPTH-1:0]    ROB_head_index,
    input  logic [LOG_ROB_DEPTH-1:0]    ROB_tail_index,

    output logic                        restore_checkpoint_valid,
    output logic                        restore_checkpoint_speculate_failed,
    output logic [LOG_ROB_DEPTH-1:0]    restore_checkpoint_ROB_index,
    output logic [LOG_CKPT_COLUMNS-1:0] restore_checkpoint_safe_column,
    input  logic                        restore_checkpoint_success,

    output logic [LOG_ROB_DEPTH-1:0]    ROB_read_index,
    input  logic                        ROB_read_writes_reg,
    input  logic [ARCH_REG_W-1:0]       ROB_read_dest_arch_reg_tag,
    input  logic [PHYS_REG_W-1:0]       ROB_read_safe_dest_phys_reg_tag,
    input  logic [PHYS_REG_W-1:0]       ROB_read_speculated_dest_phys_reg_tag,

    output logic                        revert_valid,
    output logic [ARCH_REG_W-1:0]       revert_dest_arch_reg_tag,
    output logic [PHYS_REG_W-1:0]       revert_safe_dest_phys_reg_tag,
    output logic [PHYS_REG_W-1:0]       revert_speculated_dest_phys_reg_tag,

    output logic                        ROB_tail_set_valid,
    output logic [LOG_ROB_DEPTH-1:0]    ROB_tail_set_index,

    output logic                        dispatch_stall
);

    localparam int unsigned            IDX_W    = LOG_ROB_DEPTH;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(ROB_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESTORE_TRY,
        S_WALK,
        S_DONE
    } state_t;

    state_t                      state, state_nxt;
    logic [IDX_W-1:0]            target, target_nxt;
    logic [IDX_W-1:0]            ptr, ptr_nxt;
    logic [LOG_CKPT_COLUMNS-1:0] column, column_nxt;
    logic                        error_nxt;

    logic [IDX_W-1:0]            kill_age, tail_age, target_age;
    logic [IDX_W-1:0]            tail_minus_one, target_plus_one, ptr_minus_one;
    logic                        kill_legal, kill_older, retarget;

    // Ages relative to the head; subtraction wraps modulo the ROB depth.
    always_comb begin
        kill_age        = kill_ROB_index - ROB_head_index;
        tail_age        = ROB_tail_index - ROB_head_index;
        target_age      = target - ROB_head_index;
        kill_legal      = (kill_age < tail_age);
        kill_older      = (kill_age < target_age);
        retarget        = kill_valid && kill_legal && kill_older && (state != S_IDLE);
        tail_minus_one  = ROB_tail_index - IDX_W'(1);
        target_plus_one = target + IDX_W'(1);
        ptr_minus_one   = (ptr == '0) ? LAST_IDX : ptr - IDX_W'(1);
    end

    // State and recovery bookkeeping registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            target    <= '0;
            ptr       <= '0;
            column    <= '0;
            DUT_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            ptr       <= ptr_nxt;
            column    <= column_nxt;
            DUT_error <= error_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt                           = state;
        target_nxt                          = target;
        ptr_nxt                             = ptr;
        column_nxt                          = column;
        restore_checkpoint_valid            = 1'b0;
        restore_checkpoint_speculate_failed = 1'b0;
        restore_checkpoint_ROB_index        = target;
        restore_checkpoint_safe_column      = column;
        ROB_read_index                      = ptr;
        revert_valid                        = 1'b0;
        revert_dest_arch_reg_tag            = '0;
        revert_safe_dest_phys_reg_tag       = '0;
        revert_speculated_dest_phys_reg_tag = '0;
        ROB_tail_set_valid                  = 1'b0;
        ROB_tail_set_index                  = target_plus_one;

        case (state)
            S_IDLE: begin
                if (kill_valid && kill_legal) begin
                    target_nxt = kill_ROB_index;
                    column_nxt = kill_checkpoint_column;
                    ptr_nxt    = tail_minus_one;
                    // Killer is already the youngest entry: nothing to undo.
                    state_nxt  = (tail_minus_one == kill_ROB_index) ? S_DONE : S_RESTORE_TRY;
                end
            end
            S_RESTORE_TRY: begin
                restore_checkpoint_valid            = 1'b1;
                restore_checkpoint_speculate_failed = 1'b1;
                if (restore_checkpoint_success) begin
                    ptr_nxt   = target;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_WALK;
                end
            end
            S_WALK: begin
                revert_valid = ROB_read_writes_reg;
                if (ROB_read_writes_reg) begin
                    revert_dest_arch_reg_tag            = ROB_read_dest_arch_reg_tag;
                    revert_safe_dest_phys_reg_tag       = ROB_read_safe_dest_phys_reg_tag;
                    revert_speculated_dest_phys_reg_tag = ROB_read_speculated_dest_phys_reg_tag;
                end
                if (ptr == target_plus_one) begin
                    state_nxt = S_DONE;
                end else begin
                    ptr_nxt = ptr_minus_one;
                end
            end
            S_DONE: begin
                ROB_tail_set_valid = !retarget;
                state_nxt          = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // An older kill during recovery extends the walk. Everything younger than
        // the point already reached is undone, so the walk continues from there.
        if (retarget) begin
            target_nxt = kill_ROB_index;
            column_nxt = kill_checkpoint_column;
            state_nxt  = S_WALK;
            if (state == S_WALK) begin
                ptr_nxt = ptr_minus_one;
            end else if (state == S_DONE) begin
                ptr_nxt = target;
            end
        end

        error_nxt = (kill_valid && !kill_legal) ||
                    (revert_valid && (ROB_read_speculated_dest_phys_reg_tag == '0));
    end

    assign dispatch_stall = kill_valid || (state != S_IDLE);

endmodule

// File: tb/tb_reg_map_recovery_sequencer.sv
module tb_reg_map_recovery_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       DUT_error;
    logic       kill_valid;
    logic [3:0] kill_ROB_index;
    logic [1:0] kill_checkpoint_column;
    logic [3:0] ROB_head_index;
    logic [3:0] ROB_tail_index;
    logic       restore_checkpoint_valid;
    logic       restore_checkpoint_speculate_failed;
    logic [3:0] restore_checkpoint_ROB_index;
    logic [1:0] restore_checkpoint_safe_column;
    logic       restore_checkpoint_success;
    logic [3:0] ROB_read_index;
    logic       ROB_read_writes_reg;
    logic [4:0] ROB_read_dest_arch_reg_tag;
    logic [5:0] ROB_read_safe_dest_phys_reg_tag;
    logic [5:0] ROB_read_speculated_dest_phys_reg_tag;
    logic       revert_valid;
    logic [4:0] revert_dest_arch_reg_tag;
    logic [5:0] revert_safe_dest_phys_reg_tag;
    logic [5:0] revert_speculated_dest_phys_reg_tag;
    logic       ROB_tail_set_valid;
    logic [3:0] ROB_tail_set_index;
    logic       dispatch_stall;

    int errors = 0;
    int checks = 0;
    int revert_cnt = 0;
    int restore_cnt = 0;
    int base;

    logic       rob_writes [16];
    logic [4:0] rob_arch   [16];
    logic [5:0] rob_safe   [16];
    logic [5:0] rob_spec   [16];

    always #5 CLK = ~CLK;

    reg_map_recovery_sequencer dut (
        .CLK                                   (CLK),
        .nRST                                  (nRST),
        .DUT_error                             (DUT_error),
        .kill_valid                            (kill_valid),
        .kill_ROB_index                        (kill_ROB_index),
        .kill_checkpoint_column                (kill_checkpoint_column),
        .ROB_head_index                        (ROB_head_index),
        .ROB_tail_index                        (ROB_tail_index),
        .restore_checkpoint_valid              (restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed   (restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index          (restore_checkpoint_ROB_index),
        .restore_checkpoint_safe_column        (restore_checkpoint_safe_column),
        .restore_checkpoint_success            (restore_checkpoint_success),
        .ROB_read_index                        (ROB_read_index),
        .ROB_read_writes_reg                   (ROB_read_writes_reg),
        .ROB_read_dest_arch_reg_tag            (ROB_read_dest_arch_reg_tag),
        .ROB_read_safe_dest_phys_reg_tag       (ROB_read_safe_dest_phys_reg_tag),
        .ROB_read_speculated_dest_phys_reg_tag (ROB_read_speculated_dest_phys_reg_tag),
        .revert_valid                          (revert_valid),
        .revert_dest_arch_reg_tag              (revert_dest_arch_reg_tag),
        .revert_safe_dest_phys_reg_tag         (revert_safe_dest_phys_reg_tag),
        .revert_speculated_dest_phys_reg_tag   (revert_speculated_dest_phys_reg_tag),
        .ROB_tail_set_valid                    (ROB_tail_set_valid),
        .ROB_tail_set_index                    (ROB_tail_set_index),
        .dispatch_stall                        (dispatch_stall)
    );

    // Combinational ROB read port model.
    always_comb begin
        ROB_read_writes_reg                   = rob_writes[ROB_read_index];
        ROB_read_dest_arch_reg_tag            = rob_arch[ROB_read_index];
        ROB_read_safe_dest_phys_reg_tag       = rob_safe[ROB_read_index];
        ROB_read_speculated_dest_phys_reg_tag = rob_spec[ROB_read_index];
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge CLK) begin
        if (revert_valid)             revert_cnt  <= revert_cnt + 1;
        if (restore_checkpoint_valid) restore_cnt <= restore_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rob_writes[i] = 1'b1;
            rob_arch[i]   = 5'(i);
            rob_safe[i]   = 6'(16 + i);
            rob_spec[i]   = 6'(32 + i);
        end
        nRST = 1'b0;
        kill_valid = 1'b0;
        kill_ROB_index = '0;
        kill_checkpoint_column = '0;
        ROB_head_index = '0;
        ROB_tail_index = '0;
        restore_checkpoint_success = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_err",      32'(DUT_error), 0);
        chk("rst_stall",    32'(dispatch_stall), 0);
        chk("rst_restore",  32'(restore_checkpoint_valid), 0);
        chk("rst_revert",   32'(revert_valid), 0);
        chk("rst_tailset",  32'(ROB_tail_set_valid), 0);
        chk("rst_readidx",  32'(ROB_read_index), 0);
        nRST = 1'b1;
        nxt();

        // Checkpoint restore succeeds.
        ROB_head_index = 4'd0; ROB_tail_index = 4'd7;
        kill_valid = 1'b1; kill_ROB_index = 4'd3; kill_checkpoint_column = 2'd2;
        restore_checkpoint_success = 1'b1;
        base = revert_cnt;
        #1;
        chk("t1_c0_stall",   32'(dispatch_stall), 1);
        chk("t1_c0_restore", 32'(restore_checkpoint_valid), 0);
        nxt(); kill_valid = 1'b0; #1;
        chk("t1_c1_restore", 32'(restore_checkpoint_valid), 1);
        chk("t1_c1_specf",   32'(restore_checkpoint_speculate_failed), 1);
        chk("t1_c1_ridx",    32'(restore_checkpoint_ROB_index), 3);
        chk("t1_c1_rcol",    32'(restore_checkpoint_safe_column), 2);
        chk("t1_c1_revert",  32'(revert_valid), 0);
        chk("t1_c1_stall",   32'(dispatch_stall), 1);
        nxt(); #1;
        chk("t1_c2_tsv",     32'(ROB_tail_set_valid), 1);
        chk("t1_c2_tsi",     32'(ROB_tail_set_index), 4);
        chk("t1_c2_restore", 32'(restore_checkpoint_valid), 0);
        chk("t1_c2_stall",   32'(dispatch_stall), 1);
        nxt(); #1;
        chk("t1_c3_stall",   32'(dispatch_stall), 0);
        chk("t1_c3_tsv",     32'(ROB_tail_set_valid), 0);
        chk("t1_reverts",    32'(revert_cnt - base), 0);

        // Restore fails: walk 6,5,4.
        kill_valid = 1'b1; kill_ROB_index = 4'd3; kill_checkpoint_column = 2'd2;
        restore_checkpoint_success = 1'b0;
        base = revert_cnt;
        nxt(); kill_valid = 1'b0; #1;
        chk("t2_c1_restore", 32'(restore_checkpoint_valid), 1);
        nxt(); #1;
        chk("t2_c2_rd",      32'(ROB_read_index), 6);
        chk("t2_c2_rv",      32'(revert_valid), 1);
        chk("t2_c2_arch",    32'(revert_dest_arch_reg_tag), 6);
        chk("t2_c2_safe",    32'(revert_safe_dest_phys_reg_tag), 'h16);
        chk("t2_c2_spec",    32'(revert_speculated_dest_phys_reg_tag), 'h26);
        chk("t2_c2_restore", 32'(restore_checkpoint_valid), 0);
        nxt(); #1;
        chk("t2_c3_rd",      32'(ROB_read_index), 5);
        chk("t2_c3_arch",    32'(revert_dest_arch_reg_tag), 5);
        nxt(); #1;
        chk("t2_c4_rd",      32'(ROB_read_index), 4);
        chk("t2_c4_spec",    32'(revert_speculated_dest_phys_reg_tag), 'h24);
        chk("t2_c4_tsv",     32'(ROB_tail_set_valid), 0);
        nxt(); #1;
        chk("t2_c5_tsv",     32'(ROB_tail_set_valid), 1);
        chk("t2_c5_tsi",     32'(ROB_tail_set_index), 4);
        chk("t2_c5_rv",      32'(revert_valid), 0);
        nxt(); #1;
        chk("t2_c6_stall",   32'(dispatch_stall), 0);
        chk("t2_reverts",    32'(revert_cnt - base), 3);

        // Wrap around index 0; entry 0 has no dest, entry 1 carries a zero tag.
        rob_writes[0] = 1'b0;
        rob_spec[1]   = 6'd0;
        ROB_head_index = 4'd14; ROB_tail_index = 4'd2;
        kill_valid = 1'b1; kill_ROB_index = 4'd15; kill_checkpoint_column = 2'd3;
        nxt(); kill_valid = 1'b0; #1;
        chk("t3_c1_restore", 32'(restore_checkpoint_valid), 1);
        chk("t3_c1_ridx",    32'(restore_checkpoint_ROB_index), 15);
        nxt(); #1;
        chk("t3_c2_rd",      32'(ROB_read_index), 1);
        chk("t3_c2_rv",      32'(revert_valid), 1);
        chk("t3_c2_err",     32'(DUT_error), 0);
        nxt(); #1;
        chk("t3_c3_rd",      32'(ROB_read_index), 0);
        chk("t3_c3_rv",      32'(revert_valid), 0);
        chk("t3_c3_err",     32'(DUT_error), 1);
        nxt(); #1;
        chk("t3_c4_tsv",     32'(ROB_tail_set_valid), 1);
        chk("t3_c4_tsi",     32'(ROB_tail_set_index), 0);
        chk("t3_c4_err",     32'(DUT_error), 0);
        nxt();
        rob_writes[0] = 1'b1;
        rob_spec[1]   = 6'd33;

        // Mid-walk retarget from 5 to 2.
        ROB_head_index = 4'd0; ROB_tail_index = 4'd9;
        kill_valid = 1'b1; kill_ROB_index = 4'd5; kill_checkpoint_column = 2'd0;
        nxt(); kill_valid = 1'b0; #1;
        chk("t4_c1_restore", 32'(restore_checkpoint_valid), 1);
        nxt(); #1;
        chk("t4_c2_rd",      32'(ROB_read_index), 8);
        nxt();
        kill_valid = 1'b1; kill_ROB_index = 4'd2; kill_checkpoint_column = 2'd1;
        #1;
        chk("t4_c3_rd",      32'(ROB_read_index), 7);
        chk("t4_c3_rv",      32'(revert_valid), 1);
        nxt(); kill_valid = 1'b0; #1;
        chk("t4_c4_rd",      32'(ROB_read_index), 6);
        nxt(); #1;
        chk("t4_c5_rd",      32'(ROB_read_index), 5);
        chk("t4_c5_tsv",     32'(ROB_tail_set_valid), 0);
        nxt(); #1;
        chk("t4_c6_rd",      32'(ROB_read_index), 4);
        nxt(); #1;
        chk("t4_c7_rd",      32'(ROB_read_index), 3);
        chk("t4_c7_tsv",     32'(ROB_tail_set_valid), 0);
        nxt(); #1;
        chk("t4_c8_tsv",     32'(ROB_tail_set_valid), 1);
        chk("t4_c8_tsi",     32'(ROB_tail_set_index), 3);
        nxt(); #1;
        chk("t4_c9_stall",   32'(dispatch_stall), 0);

        // Killer is the youngest entry.
        ROB_head_index = 4'd0; ROB_tail_index = 4'd4;
        kill_valid = 1'b1; kill_ROB_index = 4'd3; kill_checkpoint_column = 2'd1;
        base = restore_cnt;
        nxt(); kill_valid = 1'b0; #1;
        chk("t5_c1_tsv",     32'(ROB_tail_set_valid), 1);
        chk("t5_c1_tsi",     32'(ROB_tail_set_index), 4);
        chk("t5_c1_rv",      32'(revert_valid), 0);
        nxt(); #1;
        chk("t5_c2_stall",   32'(dispatch_stall), 0);
        chk("t5_restores",   32'(restore_cnt - base), 0);

        // Kill beyond the tail is a protocol violation.
        ROB_head_index = 4'd0; ROB_tail_index = 4'd6;
        kill_valid = 1'b1; kill_ROB_index = 4'd9; kill_checkpoint_column = 2'd0;
        #1;
        chk("t6_c0_stall",   32'(dispatch_stall), 1);
        nxt(); kill_valid = 1'b0; #1;
        chk("t6_c1_err",     32'(DUT_error), 1);
        chk("t6_c1_stall",   32'(dispatch_stall), 0);
        chk("t6_c1_restore", 32'(restore_checkpoint_valid), 0);
        chk("t6_c1_tsv",     32'(ROB_tail_set_valid), 0);
        nxt(); #1;
        chk("t6_c2_err",     32'(DUT_error), 0);

        // Asynchronous reset in the middle of a walk.
        ROB_head_index = 4'd0; ROB_tail_index = 4'd9;
        kill_valid = 1'b1; kill_ROB_index = 4'd5; kill_checkpoint_column = 2'd0;
        nxt(); kill_valid = 1'b0;
        nxt(); #1;
        chk("t7_walk_rv",    32'(revert_valid), 1);
        #1;
        nRST = 1'b0;
        #1;
        chk("t7_rst_rv",     32'(revert_valid), 0);
        chk("t7_rst_stall",  32'(dispatch_stall), 0);
        chk("t7_rst_rd",     32'(ROB_read_index), 0);
        chk("t7_rst_tsv",    32'(ROB_tail_set_valid), 0);
        @(negedge CLK);
        nRST = 1'b1;
        base = revert_cnt;
        nxt(); #1;
        chk("t7_idle_stall", 32'(dispatch_stall), 0);
        ROB_tail_index = 4'd4;
        kill_valid = 1'b1; kill_ROB_index = 4'd3;
        nxt(); kill_valid = 1'b0; #1;
        chk("t7_tsv",        32'(ROB_tail_set_valid), 1);
        chk("t7_tsi",        32'(ROB_tail_set_index), 4);
        chk("t7_reverts",    32'(revert_cnt - base), 0);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
